// File: rtl/fifo_collector_if.sv
// Handshake and readback bundle between the output FIFO, the collector and the bench.
// The checksum member exists only when FIFO_COLLECTOR_CHECKSUM_EN is defined.
interface fifo_collector_if #(
  parameter int DATA_WIDTH       = 32,
  parameter int WORDS_PER_RECORD = 3,
  parameter int ADDR_WIDTH       = 18
);
  logic                                     start;
  logic                                     empty;
  logic [DATA_WIDTH-1:0]                    data_in;
  logic                                     rd_en;
  logic [ADDR_WIDTH-1:0]                    rd_addr;
  logic [DATA_WIDTH*WORDS_PER_RECORD-1:0]   rd_data;
  logic [ADDR_WIDTH:0]                      record_count;
  logic                                     busy;
  logic                                     done;
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]                    checksum;
`endif

  modport slave (
    input  start, empty, data_in, rd_addr,
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    output checksum,
`endif
    output rd_en, rd_data, record_count, busy, done
  );

  modport master (
    output start, empty, data_in, rd_addr,
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    input  checksum,
`endif
    input  rd_en, rd_data, record_count, busy, done
  );
endinterface

// File: rtl/fifo_collector.sv
// Drains a layer output FIFO, packs WORDS_PER_RECORD words per record into a result memory
// with a registered readback port. Define FIFO_COLLECTOR_CHECKSUM_EN to add a running checksum.
module fifo_collector #(
  parameter int DATA_WIDTH       = 32,
  parameter int WORDS_PER_RECORD = 3,
  parameter int NUM_RECORDS      = 173056,
  parameter int ADDR_WIDTH       = 18
) (
  input  logic          Clk,
  input  logic          Reset_n,
  fifo_collector_if.slave bus
);
  localparam int RECORD_WIDTH = DATA_WIDTH * WORDS_PER_RECORD;
  localparam int TOTAL_WORDS  = NUM_RECORDS * WORDS_PER_RECORD;
  localparam int CNT_W        = $clog2(TOTAL_WORDS + 1);
  localparam int IDX_W        = (WORDS_PER_RECORD > 1) ? $clog2(WORDS_PER_RECORD) : 1;
  localparam int RCNT_W       = ADDR_WIDTH + 1;
  localparam int DEPTH        = 1 << ADDR_WIDTH;

  localparam logic [CNT_W-1:0]  TOTAL_CNT = CNT_W'(TOTAL_WORDS);
  localparam logic [RCNT_W-1:0] REC_MAX   = RCNT_W'(NUM_RECORDS);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS_PER_RECORD - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]              state;
  logic [CNT_W-1:0]        issued;
  logic [CNT_W-1:0]        received;
  logic [IDX_W-1:0]        word_idx;
  logic                    rd_vld;
  logic [RCNT_W-1:0]       record_count;
  logic [RECORD_WIDTH-1:0] pack;
  logic [RECORD_WIDTH-1:0] record_next;
  logic [RECORD_WIDTH-1:0] rd_data;
  logic [RECORD_WIDTH-1:0] mem [DEPTH];
  logic                    rd_en;
  logic                    start_run;
  logic                    mem_we;

  // The issue limit stops popping once every word of the run has been requested.
  assign rd_en     = (state == RUN) && !bus.empty && (issued < TOTAL_CNT);
  assign start_run = bus.start && (state != RUN);
  assign mem_we    = (state == RUN) && rd_vld && (word_idx == LAST_IDX) &&
                     (record_count < REC_MAX);

  assign bus.rd_en        = rd_en;
  assign bus.busy         = (state == RUN);
  assign bus.done         = (state == DONE);
  assign bus.record_count = record_count;
  assign bus.rd_data      = rd_data;

  // Merge the arriving word into its slot so a completing record includes it.
  always_comb begin
    record_next = pack;
    for (int s = 0; s < WORDS_PER_RECORD; s++) begin
      if (word_idx == IDX_W'(s)) begin
        record_next[s*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      issued       <= '0;
      received     <= '0;
      word_idx     <= '0;
      rd_vld       <= 1'b0;
      record_count <= '0;
      pack         <= '0;
    end else begin
      rd_vld <= rd_en;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= RUN;
            issued       <= '0;
            received     <= '0;
            word_idx     <= '0;
            record_count <= '0;
          end
        end
        RUN: begin
          if (rd_en) begin
            issued <= issued + 1'b1;
          end
          if (rd_vld) begin
            received <= received + 1'b1;
            pack     <= record_next;
            if (word_idx == LAST_IDX) begin
              word_idx <= '0;
              if (record_count < REC_MAX) begin
                record_count <= record_count + 1'b1;
              end
            end else begin
              word_idx <= word_idx + 1'b1;
            end
            if (received == TOTAL_CNT - 1'b1) begin
              state <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem[record_count[ADDR_WIDTH-1:0]] <= record_next;
    end
  end

  // Read-before-write: a same-cycle write to rd_addr returns the old record.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[bus.rd_addr];
    end
  end

`ifdef FIFO_COLLECTOR_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;
  logic [DATA_WIDTH-1:0] checksum_mix;

  assign checksum_mix = checksum ^ bus.data_in;
  assign bus.checksum = checksum;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      checksum <= '0;
    end else if (start_run) begin
      checksum <= '0;
    end else if ((state == RUN) && rd_vld) begin
      checksum <= {checksum_mix[DATA_WIDTH-2:0], checksum_mix[DATA_WIDTH-1]};
    end
  end
`else
  logic unused_start_run;
  assign unused_start_run = start_run;
`endif

endmodule

// File: tb/tb_fifo_collector.sv
// Directed bench for fifo_collector: behavioural FIFO, record scoreboard, readback checks.
module tb_fifo_collector;
  localparam int DW  = 32;
  localparam int W   = 3;
  localparam int NR  = 4;
  localparam int AW  = 2;
  localparam int RW  = DW * W;

  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  fifo_collector_if #(.DATA_WIDTH(DW), .WORDS_PER_RECORD(W), .ADDR_WIDTH(AW)) bus ();

  fifo_collector #(
    .DATA_WIDTH(DW), .WORDS_PER_RECORD(W), .NUM_RECORDS(NR), .ADDR_WIDTH(AW)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .bus(bus)
  );

  logic [DW-1:0] fifo_mem [128];
  int            wr_cnt = 0;
  int            rd_ptr = 0;
  int            pop_count = 0;
  int            viol_count = 0;
  logic          flush = 1'b0;
  logic          hold = 1'b0;
  logic          toggle_mode = 1'b0;
  logic          toggle_blk = 1'b0;

  int            n_checks = 0;
  int            n_fail = 0;
  int            base;
  logic [RW-1:0] exp_q [$];
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
  logic [DW-1:0] ck_model;
`endif

  // Behavioural FIFO: read data appears the cycle after rd_en, like a registered FIFO.
  assign bus.empty = hold || (toggle_mode && toggle_blk) || (rd_ptr >= wr_cnt);

  always @(posedge Clk) begin
    toggle_blk <= toggle_mode ? ~toggle_blk : 1'b0;
    if (bus.rd_en && bus.empty) viol_count <= viol_count + 1;
    if (flush) begin
      rd_ptr <= wr_cnt;
    end else if (bus.rd_en) begin
      bus.data_in <= fifo_mem[rd_ptr[6:0]];
      rd_ptr      <= rd_ptr + 1;
      pop_count   <= pop_count + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Loads n words into the FIFO and predicts the first nrec records (and their checksum).
  task automatic applyStimulus(input logic [DW-1:0] first, input int n, input int nrec);
    logic [RW-1:0] rec;
    logic [DW-1:0] w;
    rec = '0;
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    ck_model = '0;
`endif
    for (int i = 0; i < n; i++) begin
      w = first + DW'(i);
      fifo_mem[wr_cnt[6:0]] = w;
      wr_cnt++;
      if (i < nrec * W) begin
        rec[(i % W)*DW +: DW] = w;
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
        ck_model = {ck_model[DW-2:0] ^ w[DW-2:0], ck_model[DW-1] ^ w[DW-1]};
`endif
        if ((i % W) == W - 1) exp_q.push_back(rec);
      end
    end
  endtask

  task automatic pulseStart();
    @(negedge Clk); bus.start = 1'b1;
    @(negedge Clk); bus.start = 1'b0;
  endtask

  task automatic flushFifo();
    @(negedge Clk); flush = 1'b1;
    @(negedge Clk); flush = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int k;
    k = 0;
    while (!bus.done && k < budget) begin
      @(negedge Clk);
      k++;
    end
    checkOutput(tag, 128'(bus.done), 128'(1));
  endtask

  task automatic readbackAll(input string tag);
    logic [RW-1:0] exp;
    for (int a = 0; a < NR; a++) begin
      @(negedge Clk); bus.rd_addr = AW'(a);
      @(negedge Clk);
      if (exp_q.size() == 0) begin
        checkOutput({tag, "_sb_empty"}, 128'(0), 128'(1));
      end else begin
        exp = exp_q.pop_front();
        checkOutput(tag, 128'(bus.rd_data), 128'(exp));
      end
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.start   = 1'b0;
    bus.rd_addr = '0;
    Reset_n     = 1'b0;
    repeat (3) @(negedge Clk);
    checkOutput("rst_rd_en", 128'(bus.rd_en), 128'(0));
    checkOutput("rst_busy", 128'(bus.busy), 128'(0));
    checkOutput("rst_done", 128'(bus.done), 128'(0));
    checkOutput("rst_count", 128'(bus.record_count), 128'(0));
    checkOutput("rst_rd_data", 128'(bus.rd_data), 128'(0));
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    checkOutput("rst_checksum", 128'(bus.checksum), 128'(0));
`endif
    Reset_n = 1'b1;
    @(negedge Clk);

    // Steady FIFO: twelve back-to-back pops, done one cycle after the last data beat.
    applyStimulus(32'h1, 12, NR);
    base = pop_count;
    pulseStart();
    for (int i = 0; i < 12; i++) begin
      checkOutput("t1_rd_en_run", 128'(bus.rd_en), 128'(1));
      @(negedge Clk);
    end
    checkOutput("t1_rd_en_stop", 128'(bus.rd_en), 128'(0));
    checkOutput("t1_done_early", 128'(bus.done), 128'(0));
    @(negedge Clk);
    checkOutput("t1_done_rise", 128'(bus.done), 128'(1));
    checkOutput("t1_busy", 128'(bus.busy), 128'(0));
    checkOutput("t1_count", 128'(bus.record_count), 128'(NR));
    checkOutput("t1_pops", 128'(pop_count - base), 128'(12));
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    checkOutput("t1_checksum", 128'(bus.checksum), 128'(ck_model));
`endif
    readbackAll("t1_record");
    @(negedge Clk); bus.rd_addr = 2'd0;
    @(negedge Clk);
    checkOutput("t1_addr0", 128'(bus.rd_data), 128'(96'h00000003_00000002_00000001));
    bus.rd_addr = 2'd3;
    @(negedge Clk);
    checkOutput("t1_addr3", 128'(bus.rd_data), 128'(96'h0000000C_0000000B_0000000A));

    // Restart from DONE with empty toggling every cycle and surplus words in the FIFO.
    applyStimulus(32'd13, 14, NR);
    toggle_mode = 1'b1;
    base = pop_count;
    pulseStart();
    checkOutput("t2_count_clear", 128'(bus.record_count), 128'(0));
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    checkOutput("t2_checksum_clear", 128'(bus.checksum), 128'(0));
`endif
    waitDone("t2_done", 200);
    checkOutput("t2_pops", 128'(pop_count - base), 128'(12));
    checkOutput("t2_no_pop_when_empty", 128'(viol_count), 128'(0));
    checkOutput("t2_count", 128'(bus.record_count), 128'(NR));
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    checkOutput("t2_checksum", 128'(bus.checksum), 128'(ck_model));
`endif
    readbackAll("t2_record");
    toggle_mode = 1'b0;

    // Reset after five pops, then a fresh run must land at address 0.
    flushFifo();
    applyStimulus(32'h100, 12, 0);
    base = pop_count;
    pulseStart();
    for (int k = 0; k < 50 && (pop_count - base) < 5; k++) @(negedge Clk);
    checkOutput("t3_pops_before_reset", 128'(pop_count - base), 128'(5));
    Reset_n = 1'b0;
    #1;
    checkOutput("t3_rst_rd_en", 128'(bus.rd_en), 128'(0));
    checkOutput("t3_rst_busy", 128'(bus.busy), 128'(0));
    checkOutput("t3_rst_count", 128'(bus.record_count), 128'(0));
    @(negedge Clk);
    Reset_n = 1'b1;
    flushFifo();
    applyStimulus(32'h200, 12, NR);
    base = pop_count;
    pulseStart();
    for (int k = 0; k < 50 && bus.record_count == 0; k++) @(negedge Clk);
    pulseStart();
    checkOutput("t4_start_in_run_busy", 128'(bus.busy), 128'(1));
    checkOutput("t4_start_in_run_count", 128'(bus.record_count >= 1), 128'(1));
    waitDone("t4_done", 200);
    checkOutput("t4_pops", 128'(pop_count - base), 128'(12));
    readbackAll("t4_record");

    // Empty held high in RUN: no pops, still busy, not done.
    hold = 1'b1;
    applyStimulus(32'h300, 12, NR);
    base = pop_count;
    pulseStart();
    for (int i = 0; i < 100; i++) begin
      checkOutput("t5_no_rd_en", 128'(bus.rd_en), 128'(0));
      @(negedge Clk);
    end
    checkOutput("t5_busy", 128'(bus.busy), 128'(1));
    checkOutput("t5_done", 128'(bus.done), 128'(0));
    hold = 1'b0;
    waitDone("t5_done_after_release", 200);
    checkOutput("t5_pops", 128'(pop_count - base), 128'(12));
`ifdef FIFO_COLLECTOR_CHECKSUM_EN
    checkOutput("t5_checksum", 128'(bus.checksum), 128'(ck_model));
`endif
    readbackAll("t5_record");
    checkOutput("all_no_pop_when_empty", 128'(viol_count), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fifo_collector.md
Name: fifo_collector

Overview:
- Sink-side counterpart of the bitmap stimulus generator: drains 32-bit words from a layer's output FIFO.
- Packs every WORDS_PER_RECORD words into one record and stores it in an internal result memory.
- After a fixed record count, raises done; the bench then dumps or inspects results through a registered readback port.
- Sits at the output of the YOLOv3Tiny datapath in simulation and FPGA bring-up.

Parameters:
DATA_WIDTH, 32, width of one FIFO word
WORDS_PER_RECORD, 3, words packed per record (record width = DATA_WIDTH*WORDS_PER_RECORD = 96)
NUM_RECORDS, 173056, records to collect before done
ADDR_WIDTH, 18, record address width (2^ADDR_WIDTH >= NUM_RECORDS)

Ports:
Clk  input  1  clock, all logic on rising edge
Reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; begins collection from IDLE or DONE
empty  input  1  FIFO empty flag
data_in  input  DATA_WIDTH  FIFO read data, valid the cycle after rd_en
rd_en  output  1  FIFO pop request
rd_addr  input  ADDR_WIDTH  readback record address
rd_data  output  DATA_WIDTH*WORDS_PER_RECORD  readback record, registered
record_count  output  ADDR_WIDTH+1  records written since start
busy  output  1  high in RUN
done  output  1  high in DONE

Behaviour:
Interface rule: one clock; reset is asynchronous and active-low. Clock port is Clk, reset port is Reset_n.

Reset values:
- rd_en=0, busy=0, done=0, record_count=0, rd_data=0.
- State is IDLE; issue and receive counters and the word index are cleared.
- Result memory contents are not reset.

State machine:
- IDLE: wait for start.
  - start -> RUN.
  - Clear record_count, issued-word counter, received-word counter and word index.
- RUN:
  - rd_en = !empty && (issued < NUM_RECORDS*WORDS_PER_RECORD). rd_en is combinational from empty and the counter.
  - Each rd_en increments issued.
  - A 1-cycle-delayed copy of rd_en (rd_vld) marks data_in valid. On rd_vld:
    - data_in goes into slot word_idx of the pack register; slot 0 is bits [31:0], slot 1 is [63:32], slot 2 is [95:64].
    - word_idx increments.
  - When word_idx==WORDS_PER_RECORD-1 on rd_vld, the completed record (including the word arriving this cycle) is written to mem[record_count]. In the same cycle, record_count increments and word_idx wraps to 0.
  - When the received-word count reaches NUM_RECORDS*WORDS_PER_RECORD -> DONE.
- DONE: done=1, rd_en=0. start -> RUN with the same clears as IDLE->RUN.

Rules:
- rd_en is never asserted while empty=1, nor in IDLE or DONE.
- The issue limit prevents over-reading. Exactly NUM_RECORDS*WORDS_PER_RECORD pops occur per run, even if the FIFO holds more.
- empty toggling every cycle: pops occur only on non-empty cycles; packing order is preserved.
- start while in RUN is ignored.
- Reset mid-RUN: the next state is IDLE and any partial record is discarded. A pop in flight at reset is lost.
- Readback:
  - rd_data <= mem[rd_addr] every cycle, 1-cycle latency, in any state.
  - Same-cycle write and read of the same address returns the old contents.
- record_count saturates at NUM_RECORDS.

Optional Feature:
FIFO_COLLECTOR_CHECKSUM_EN
- Defined:
  - Adds output checksum [DATA_WIDTH-1:0] and internal accumulator.
  - Reset value 0; cleared on start.
  - On each rd_vld, checksum <= (checksum XOR data_in) rotated left by 1.
  - Value is final and stable once done=1.
- Undefined: port and logic absent; all other behaviour is identical.

Test Plan:
- Use NUM_RECORDS=4. Reset, start, FIFO preloaded with words 0x1..0xC, empty low throughout -> rd_en high 12 consecutive cycles then 0. done rises 1 cycle after the last rd_vld. rd_addr=0 gives rd_data=0x00000003_00000002_00000001; rd_addr=3 gives 0x0000000C_0000000B_0000000A.
- empty alternates 1/0 each cycle with 14 words available -> exactly 12 pops, rd_en never high while empty=1, record_count=4, packing identical to the previous case.
- Assert Reset_n=0 after 5 pops -> rd_en=0, busy=0, record_count=0 immediately. Start again with fresh data -> records begin at address 0 from the new data.
- start pulsed while busy=1 -> no effect on counters. start in DONE -> record_count returns to 0, a second run overwrites mem.
- Checksum build, words 0x1..0xC -> checksum equals the reference model value. A second start clears it before accumulation.
- empty held high for 100 cycles in RUN -> no rd_en, busy stays 1, done stays 0.
